// File: rtl/m_fetchseq_pkg.sv
// m_fetchseq_pkg: shared definitions for the midgetv instruction fetch sequencer.
//   - fs_state_t : fetch state encodings (IDLE/REQ/FULL/DROP)
//   - FS_RESET_PC: default fetch address after reset
//   - fs_next_word(): sequential +4 step, modulo 2^32
package m_fetchseq_pkg;

    typedef enum logic [1:0] {
        FS_IDLE = 2'b00,
        FS_REQ  = 2'b01,
        FS_FULL = 2'b10,
        FS_DROP = 2'b11
    } fs_state_t;

    localparam logic [31:0] FS_RESET_PC = 32'h0000_0000;

    // 32-bit add; 32'hFFFF_FFFC wraps to 32'h0000_0000.
    function automatic logic [31:0] fs_next_word(input logic [31:0] a);
        return a + 32'd4;
    endfunction

endpackage

// File: rtl/m_fetchbuf.sv
// m_fetchbuf: fetch datapath.
//   Holds the prefetched word (buf_q), its illegal/compressed flag (ill_q),
//   its address (bpc_q), plus the fetch address (fadr) and next address (npc).
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   ld_buf              : capture dat_i / flag / fadr into the buffer
//   ld_npc_inc          : npc <= fadr + 4
//   ld_npc_tgt          : npc <= word-aligned new_pc (wins over ld_npc_inc)
//   ld_fadr_npc         : fadr <= npc
//   ld_fadr_tgt         : fadr <= word-aligned new_pc (wins over ld_fadr_npc)
//   dat_i, new_pc       : memory data, redirect target
//   fadr, npc           : address registers
//   buf_q, ill_q, bpc_q : buffered word, flag, address
module m_fetchbuf
    import m_fetchseq_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = FS_RESET_PC,
    parameter bit          HIGHLEVEL = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ld_buf,
    input  logic        ld_npc_inc,
    input  logic        ld_npc_tgt,
    input  logic        ld_fadr_npc,
    input  logic        ld_fadr_tgt,
    input  logic [31:0] dat_i,
    input  logic [31:0] new_pc,
    output logic [31:0] fadr,
    output logic [31:0] npc,
    output logic [31:0] buf_q,
    output logic        ill_q,
    output logic [31:0] bpc_q
);

    logic [31:0] tgt;
    logic        ill_d;
    logic        unused_lowbits;

    // Redirect targets are forced to word alignment; the low bits are discarded.
    assign tgt            = {new_pc[31:2], 2'b00};
    assign unused_lowbits = ^new_pc[1:0];

    // Anything whose two low bits are not 11 is a compressed or illegal opcode.
    // The primitive flavour expresses it as the single LUT it maps to.
    if (HIGHLEVEL) begin : g_hl
        assign ill_d = (dat_i[1:0] != 2'b11);
    end else begin : g_prim
        assign ill_d = ~(dat_i[1] & dat_i[0]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_q <= 32'h0;
            ill_q <= 1'b0;
            bpc_q <= 32'h0;
            fadr  <= RESET_PC;
            npc   <= RESET_PC;
        end else begin
            if (ld_buf) begin
                buf_q <= dat_i;
                ill_q <= ill_d;
                bpc_q <= fadr;
            end
            if (ld_npc_tgt)
                npc <= tgt;
            else if (ld_npc_inc)
                npc <= fs_next_word(fadr);
            if (ld_fadr_tgt)
                fadr <= tgt;
            else if (ld_fadr_npc)
                fadr <= npc;
        end
    end

endmodule

// File: rtl/m_fetchseq.sv
// m_fetchseq: midgetv instruction fetch sequencer.
//   Issues Wishbone-classic reads, holds one prefetched word and hands it to
//   the operation register with a one-cycle load enable. Handles +4
//   sequencing and redirects, disposing of a read that is still in flight.
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   corerunning           : 0 quiesces fetch (outstanding read still completes)
//   take                  : core consumes the buffered word this cycle
//   redirect, new_pc      : continue from new_pc (low bits ignored)
//   ack_i, dat_i          : Wishbone acknowledge and read data
//   stb_o, adr_o          : Wishbone request (cyc/stb) and word address
//   ld_instr, di_o        : operation register load enable and word
//   buf_v, ill_o, pc_o    : buffer valid, compressed/illegal flag, word address
module m_fetchseq
    import m_fetchseq_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = FS_RESET_PC,
    parameter bit          HIGHLEVEL = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        corerunning,
    input  logic        take,
    input  logic        redirect,
    input  logic [31:0] new_pc,
    input  logic        ack_i,
    input  logic [31:0] dat_i,
    output logic        stb_o,
    output logic [31:0] adr_o,
    output logic        ld_instr,
    output logic [31:0] di_o,
    output logic        buf_v,
    output logic        ill_o,
    output logic [31:0] pc_o
);

    fs_state_t   state, state_nxt;
    logic        ld_buf, ld_npc_inc, ld_npc_tgt, ld_fadr_npc, ld_fadr_tgt;
    logic [31:0] fadr, npc, buf_q, bpc_q;
    logic        ill_q;

    // Transition and datapath-enable decode. In REQ npc equals fadr unless a
    // redirect changed it, so refetching after a dropped word needs no extra
    // state. An ack outside REQ/DROP falls through every branch untouched.
    always_comb begin
        state_nxt   = state;
        ld_buf      = 1'b0;
        ld_npc_inc  = 1'b0;
        ld_npc_tgt  = 1'b0;
        ld_fadr_npc = 1'b0;
        ld_fadr_tgt = 1'b0;
        case (state)
            FS_IDLE: begin
                if (corerunning) begin
                    ld_fadr_npc = 1'b1;
                    state_nxt   = FS_REQ;
                end
            end
            FS_REQ: begin
                ld_npc_tgt = redirect;
                if (ack_i) begin
                    if (!corerunning) begin
                        state_nxt = FS_IDLE;
                    end else if (redirect) begin
                        ld_fadr_tgt = 1'b1;
                    end else begin
                        ld_buf     = 1'b1;
                        ld_npc_inc = 1'b1;
                        state_nxt  = FS_FULL;
                    end
                end else if (redirect) begin
                    state_nxt = FS_DROP;
                end
            end
            FS_DROP: begin
                // The stale read keeps its address; only npc tracks redirects.
                ld_npc_tgt = redirect;
                if (ack_i) begin
                    if (!corerunning) begin
                        state_nxt = FS_IDLE;
                    end else begin
                        ld_fadr_tgt = redirect;
                        ld_fadr_npc = !redirect;
                        state_nxt   = FS_REQ;
                    end
                end
            end
            FS_FULL: begin
                ld_npc_tgt = redirect;
                if (!corerunning) begin
                    state_nxt = FS_IDLE;
                end else if (redirect) begin
                    ld_fadr_tgt = 1'b1;
                    state_nxt   = FS_REQ;
                end else if (take) begin
                    ld_fadr_npc = 1'b1;
                    state_nxt   = FS_REQ;
                end
            end
            default: state_nxt = FS_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= FS_IDLE;
        else
            state <= state_nxt;
    end

    // Outputs decode straight from the state register, so the async reset
    // drops stb_o in the same cycle.
    assign stb_o    = (state == FS_REQ) || (state == FS_DROP);
    assign buf_v    = (state == FS_FULL);
    assign ld_instr = buf_v & take & !redirect & corerunning;
    assign adr_o    = fadr;
    assign di_o     = buf_q;
    assign ill_o    = ill_q;
    assign pc_o     = bpc_q;

    m_fetchbuf #(
        .RESET_PC  (RESET_PC),
        .HIGHLEVEL (HIGHLEVEL)
    ) u_fetchbuf (
        .clk         (clk),
        .rst_n       (rst_n),
        .ld_buf      (ld_buf),
        .ld_npc_inc  (ld_npc_inc),
        .ld_npc_tgt  (ld_npc_tgt),
        .ld_fadr_npc (ld_fadr_npc),
        .ld_fadr_tgt (ld_fadr_tgt),
        .dat_i       (dat_i),
        .new_pc      (new_pc),
        .fadr        (fadr),
        .npc         (npc),
        .buf_q       (buf_q),
        .ill_q       (ill_q),
        .bpc_q       (bpc_q)
    );

endmodule

// File: tb/tb_m_fetchseq.sv
// tb_m_fetchseq: bench for m_fetchseq. A behavioural model (read outstanding /
// read stale / word held) predicts every output each cycle; directed sections
// pin exact latencies with literal values, then a randomized section runs.
module tb_m_fetchseq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        corerunning, take, redirect, ack_i;
    logic [31:0] new_pc, dat_i;
    logic        stb_o, ld_instr, buf_v, ill_o;
    logic [31:0] adr_o, di_o, pc_o;

    int nchecks = 0;
    int nerr    = 0;
    int cyc     = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    m_fetchseq #(.RESET_PC(32'h0), .HIGHLEVEL(1'b0)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .corerunning (corerunning),
        .take        (take),
        .redirect    (redirect),
        .new_pc      (new_pc),
        .ack_i       (ack_i),
        .dat_i       (dat_i),
        .stb_o       (stb_o),
        .adr_o       (adr_o),
        .ld_instr    (ld_instr),
        .di_o        (di_o),
        .buf_v       (buf_v),
        .ill_o       (ill_o),
        .pc_o        (pc_o)
    );

    // ---------------- behavioural model ----------------
    bit          m_busy, m_stale, m_full, m_ill;
    logic [31:0] m_addr, m_next, m_word, m_pc, m_tgt;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy = 0; m_stale = 0; m_full = 0; m_ill = 0;
            m_addr = 32'h0; m_next = 32'h0; m_word = 32'h0; m_pc = 32'h0;
        end else begin
            m_tgt = {new_pc[31:2], 2'b00};
            if (m_busy) begin
                if (redirect) m_next = m_tgt;
                if (ack_i) begin
                    if (!m_stale && !redirect && corerunning) begin
                        m_word = dat_i;
                        m_ill  = (dat_i[1:0] != 2'b11);
                        m_pc   = m_addr;
                        m_next = m_addr + 32'd4;
                        m_busy = 0;
                        m_full = 1;
                    end else if (!corerunning) begin
                        m_busy  = 0;
                        m_stale = 0;
                    end else begin
                        m_addr  = m_next;
                        m_stale = 0;
                    end
                end else if (redirect) begin
                    m_stale = 1;
                end
            end else if (m_full) begin
                if (redirect) m_next = m_tgt;
                if (!corerunning) begin
                    m_full = 0;
                end else if (redirect) begin
                    m_full = 0; m_busy = 1; m_addr = m_tgt;
                end else if (take) begin
                    m_full = 0; m_busy = 1; m_addr = m_next;
                end
            end else if (corerunning) begin
                m_busy = 1;
                m_addr = m_next;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        nchecks++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s cycle=%0d got=%h exp=%h", name, cyc, got, exp);
        end
    endtask

    // ---------------- compare process ----------------
    bit          p_stb, p_ack;
    logic [31:0] p_adr;
    initial begin
        p_stb = 0; p_ack = 0; p_adr = 0;
    end

    always @(negedge clk) begin
        chk("cmp_stb_o",    {31'h0, stb_o},    {31'h0, m_busy});
        chk("cmp_adr_o",    adr_o,             m_addr);
        chk("cmp_buf_v",    {31'h0, buf_v},    {31'h0, m_full});
        chk("cmp_ld_instr", {31'h0, ld_instr},
            {31'h0, m_full & take & !redirect & corerunning});
        chk("cmp_di_o",     di_o,              m_word);
        chk("cmp_ill_o",    {31'h0, ill_o},    {31'h0, m_ill});
        chk("cmp_pc_o",     pc_o,              m_pc);
        // A request without acknowledge must still be up, at the same address.
        if (rst_n && p_stb && !p_ack) begin
            chk("stb_held", {31'h0, stb_o}, 32'h1);
            chk("adr_held", adr_o, p_adr);
        end
        p_stb = stb_o & rst_n;
        p_ack = ack_i;
        p_adr = adr_o;
    end

    // ---------------- memory responder ----------------
    int          fixed_wait = 0;     // <0: random 0..3 wait states
    bit          fixed_dat_en = 1;
    logic [31:0] fixed_dat = 32'h0;
    bit          spurious_en = 0;
    bit          fresh = 1;
    int          wcnt = 0;

    task automatic drive_mem();
        dat_i = fixed_dat_en ? fixed_dat : $urandom;
        if (stb_o) begin
            if (fresh) begin
                wcnt  = (fixed_wait < 0) ? int'($urandom_range(0, 3)) : fixed_wait;
                fresh = 0;
            end
            if (wcnt == 0) begin
                ack_i = 1;
                fresh = 1;
            end else begin
                ack_i = 0;
                wcnt--;
            end
        end else begin
            fresh = 1;
            ack_i = spurious_en && ($urandom_range(0, 7) == 0);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        drive_mem();
    endtask

    task automatic settle();
        #1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst_n = 0; corerunning = 0; take = 0; redirect = 0;
        new_pc = 32'h0; ack_i = 0; dat_i = 32'h0;

        // Reset state
        @(posedge clk); @(posedge clk); #1;
        chk("rst_stb_o",    {31'h0, stb_o},    32'h0);
        chk("rst_adr_o",    adr_o,             32'h0);
        chk("rst_buf_v",    {31'h0, buf_v},    32'h0);
        chk("rst_ld_instr", {31'h0, ld_instr}, 32'h0);
        chk("rst_pc_o",     pc_o,              32'h0);
        chk("rst_di_o",     di_o,              32'h0);
        rst_n = 1;
        tick();

        // Reset and start: zero-wait memory returns 0x13 at address 0
        fixed_wait = 0; fixed_dat = 32'h0000_0013;
        corerunning = 1;
        tick();
        settle();
        chk("start_stb_o", {31'h0, stb_o}, 32'h1);
        chk("start_adr_o", adr_o, 32'h0);
        tick();
        take = 1; fixed_wait = 3; fixed_dat = 32'h0000_0093;
        settle();
        chk("start_buf_v",    {31'h0, buf_v},    32'h1);
        chk("start_ill_o",    {31'h0, ill_o},    32'h0);
        chk("start_ld_instr", {31'h0, ld_instr}, 32'h1);
        chk("start_di_o",     di_o,              32'h0000_0013);
        chk("model_word",     m_word,            32'h0000_0013);
        tick();
        take = 0;
        settle();
        chk("seq_adr_o", adr_o, 32'h4);
        chk("model_addr", m_addr, 32'h4);

        // Wait states: 3 cycles without ack, ack in the 4th
        for (int i = 0; i < 4; i++) begin
            chk("wait_stb_o", {31'h0, stb_o}, 32'h1);
            chk("wait_adr_o", adr_o, 32'h4);
            chk("wait_buf_v", {31'h0, buf_v}, 32'h0);
            if (i < 3) tick();
        end
        chk("wait_ack_last", {31'h0, ack_i}, 32'h1);
        tick();
        settle();
        chk("wait_buf_v_rise", {31'h0, buf_v}, 32'h1);
        chk("wait_pc_o", pc_o, 32'h4);
        chk("wait_di_o", di_o, 32'h0000_0093);

        // Redirect in flight
        take = 1; fixed_wait = 3; fixed_dat = 32'hBAD0_0007;
        tick();
        take = 0; redirect = 1; new_pc = 32'h0000_0100;
        settle();
        chk("rdf_adr_o", adr_o, 32'h8);
        tick();
        redirect = 0; fixed_wait = 0; fixed_dat = 32'h0000_0117;
        settle();
        chk("rdf_drop_stb", {31'h0, stb_o}, 32'h1);
        chk("rdf_drop_adr", adr_o, 32'h8);
        tick(); tick();
        settle();
        chk("rdf_old_adr", adr_o, 32'h8);
        tick();
        settle();
        chk("rdf_new_adr",   adr_o, 32'h0000_0100);
        chk("rdf_new_bufv",  {31'h0, buf_v}, 32'h0);
        tick();
        settle();
        chk("rdf_pc_o", pc_o, 32'h0000_0100);
        chk("rdf_di_o", di_o, 32'h0000_0117);

        // Simultaneous take and redirect
        take = 1; redirect = 1; new_pc = 32'h0000_0203; fixed_dat = 32'h0000_0233;
        settle();
        chk("tr_ld_instr", {31'h0, ld_instr}, 32'h0);
        tick();
        take = 0; redirect = 0;
        settle();
        chk("tr_adr_o", adr_o, 32'h0000_0200);
        chk("tr_buf_v", {31'h0, buf_v}, 32'h0);
        tick();
        settle();
        chk("tr_pc_o", pc_o, 32'h0000_0200);

        // Halt in FULL
        corerunning = 0; take = 1;
        settle();
        chk("halt_ld0", {31'h0, ld_instr}, 32'h0);
        tick();
        settle();
        chk("halt_buf_v", {31'h0, buf_v}, 32'h0);
        chk("halt_stb_o", {31'h0, stb_o}, 32'h0);
        tick();
        settle();
        chk("halt_ld1", {31'h0, ld_instr}, 32'h0);
        take = 0; corerunning = 1; fixed_wait = 2; fixed_dat = 32'h1111_1113;
        // Halt in REQ: stb held until ack, then idle
        tick();
        corerunning = 0;
        settle();
        chk("hreq_adr_o", adr_o, 32'h0000_0204);
        chk("hreq_stb0", {31'h0, stb_o}, 32'h1);
        tick();
        settle();
        chk("hreq_stb1", {31'h0, stb_o}, 32'h1);
        tick();
        settle();
        chk("hreq_stb2", {31'h0, stb_o}, 32'h1);
        tick();
        settle();
        chk("hreq_idle_stb", {31'h0, stb_o}, 32'h0);
        chk("hreq_idle_bufv", {31'h0, buf_v}, 32'h0);
        chk("hreq_pc_kept", pc_o, 32'h0000_0200);

        // Wrap and illegal
        corerunning = 1; fixed_wait = 0; fixed_dat = 32'h0000_1213;
        tick();
        settle();
        chk("wrap_refetch_adr", adr_o, 32'h0000_0204);
        tick();
        redirect = 1; new_pc = 32'hFFFF_FFFF; fixed_dat = 32'h0000_0001;
        tick();
        redirect = 0;
        settle();
        chk("wrap_adr_top", adr_o, 32'hFFFF_FFFC);
        tick();
        take = 1; fixed_wait = 3;
        settle();
        chk("wrap_ill_o", {31'h0, ill_o}, 32'h1);
        chk("wrap_pc_o", pc_o, 32'hFFFF_FFFC);
        chk("wrap_ld_instr", {31'h0, ld_instr}, 32'h1);
        chk("model_ill", {31'h0, m_ill}, 32'h1);
        tick();
        take = 0;
        settle();
        chk("wrap_adr_zero", adr_o, 32'h0);
        chk("wrap_stb_o", {31'h0, stb_o}, 32'h1);
        // Async reset mid-REQ
        #1;
        rst_n = 0;
        #1;
        chk("arst_stb_o", {31'h0, stb_o}, 32'h0);
        chk("arst_buf_v", {31'h0, buf_v}, 32'h0);
        chk("arst_ill_o", {31'h0, ill_o}, 32'h0);
        @(posedge clk); #1;
        rst_n = 1; corerunning = 0; ack_i = 1; dat_i = 32'h0000_0013;
        @(posedge clk); #1;
        ack_i = 0;
        settle();
        chk("late_ack_stb", {31'h0, stb_o}, 32'h0);
        chk("late_ack_bufv", {31'h0, buf_v}, 32'h0);

        // Randomized phase
        fixed_wait = -1; fixed_dat_en = 0; spurious_en = 1; corerunning = 1;
        for (int i = 0; i < 4000; i++) begin
            tick();
            corerunning = ($urandom_range(0, 19) != 0);
            take        = $urandom_range(0, 1);
            redirect    = ($urandom_range(0, 9) == 0);
            new_pc      = $urandom;
        end
        tick();

        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
        $finish;
    end

endmodule
